// File: rtl/mode_pkg.sv
// Shared types for the mode-request driver: wire codes on a[1:0], request FSM states
// and a counter-width helper.
package mode_pkg;

    typedef enum logic [1:0] {
        MODE_GRID   = 2'b00,
        MODE_EVOLVE = 2'b01,
        MODE_LFSR   = 2'b11
    } mode_code_t;

    typedef enum logic [1:0] {
        IDLE,
        LFSR,
        EVOLVE,
        GAP
    } req_state_t;

    localparam int NUM_BTN    = 3;
    localparam int BTN_LFSR   = 0;
    localparam int BTN_EVOLVE = 1;
    localparam int BTN_STOP   = 2;

    // GAP drives 00 like IDLE; the consumer only ever sees grid between modes.
    function automatic mode_code_t state_code(input req_state_t s);
        case (s)
            LFSR:    return MODE_LFSR;
            EVOLVE:  return MODE_EVOLVE;
            default: return MODE_GRID;
        endcase
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stability counter -> single-cycle press pulse
// on the accepted rising level. Holding the button never repeats the pulse.
module btn_debounce import mode_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/mode_request_gen.sv
// Mode-request driver: debounced buttons -> request FSM with forced 00 gap between
// non-zero codes, ack echo check. Optional auto-stop guarded by MODE_AUTO_STOP_EN.
module mode_request_gen import mode_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int unsigned ACK_CYCLES      = 4,
    parameter int unsigned RUN_CYCLES      = 2**24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_stop,
    input  logic       btn_evolve,
    input  logic       btn_lfsr,
    input  logic [1:0] active,
    output logic [1:0] a,
    output logic       busy,
    output logic       mismatch
);

    localparam int unsigned GW = cnt_width(GAP_CYCLES);
    localparam int unsigned AW = cnt_width(ACK_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_CYCLES - 1);
    localparam logic [AW-1:0] ACK_DONE = AW'(ACK_CYCLES);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw[BTN_LFSR]   = btn_lfsr;
    assign btn_raw[BTN_EVOLVE] = btn_evolve;
    assign btn_raw[BTN_STOP]   = btn_stop;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .btn    (btn_raw[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    req_state_t    state_reg, state_next;
    req_state_t    target_reg, target_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [AW-1:0] ack_cnt_reg;
    mode_code_t    a_reg;
    logic          busy_reg;
    logic          mismatch_reg;
    logic          auto_stop;

`ifdef MODE_AUTO_STOP_EN
    localparam int unsigned RW = cnt_width(RUN_CYCLES);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);

    logic [RW-1:0] run_cnt_reg;

    assign auto_stop = ((state_reg == LFSR) || (state_reg == EVOLVE)) && (run_cnt_reg == RUN_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            run_cnt_reg <= '0;
        end else if ((state_reg == LFSR) || (state_reg == EVOLVE)) begin
            run_cnt_reg <= run_cnt_reg + RW'(1);
        end
    end
`else
    logic run_unused;
    assign run_unused = (RUN_CYCLES != 0);
    assign auto_stop  = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        target_next  = target_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (press[BTN_STOP])        state_next = IDLE;
                else if (press[BTN_LFSR])   state_next = LFSR;
                else if (press[BTN_EVOLVE]) state_next = EVOLVE;
            end
            LFSR: begin
                if (press[BTN_STOP]) begin
                    state_next = IDLE;
                end else if (!press[BTN_LFSR] && press[BTN_EVOLVE]) begin
                    state_next   = GAP;
                    target_next  = EVOLVE;
                    gap_cnt_next = '0;
                end
            end
            EVOLVE: begin
                if (press[BTN_STOP]) begin
                    state_next = IDLE;
                end else if (press[BTN_LFSR]) begin
                    state_next   = GAP;
                    target_next  = LFSR;
                    gap_cnt_next = '0;
                end
            end
            GAP: begin
                if (press[BTN_STOP]) begin
                    state_next = IDLE;
                end else begin
                    // Retarget without restarting the gap count.
                    if (press[BTN_LFSR])        target_next = LFSR;
                    else if (press[BTN_EVOLVE]) target_next = EVOLVE;
                    if (gap_cnt_reg == GAP_LAST) state_next = target_next;
                    else                         gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (auto_stop) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            target_reg   <= IDLE;
            gap_cnt_reg  <= '0;
            a_reg        <= MODE_GRID;
            busy_reg     <= 1'b0;
            ack_cnt_reg  <= ACK_DONE;
            mismatch_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            target_reg  <= target_next;
            gap_cnt_reg <= gap_cnt_next;
            a_reg       <= state_code(state_next);
            busy_reg    <= (state_next != IDLE);
            if (state_code(state_next) != a_reg) ack_cnt_reg <= '0;
            else if (ack_cnt_reg != ACK_DONE)    ack_cnt_reg <= ack_cnt_reg + AW'(1);
            // Sticky until the FSM re-enters IDLE.
            if ((state_next == IDLE) && (state_reg != IDLE))
                mismatch_reg <= 1'b0;
            else if ((ack_cnt_reg == ACK_LAST) && (active != a_reg))
                mismatch_reg <= 1'b1;
        end
    end

    assign a        = a_reg;
    assign busy     = busy_reg;
    assign mismatch = mismatch_reg;

endmodule
